// File: rtl/timer_seq_ctrl_pkg.sv
// Shared definitions for the timer sequencer: FSM state encodings, mode
// constants and the default counter width.
package timer_seq_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_seq_ctrl_if.sv
// Host-side request/status bundle of the timer sequencer.
interface timer_seq_ctrl_if #(
    parameter int WIDTH = timer_seq_ctrl_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             mode;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, load_val, mode, pause, abort,
        input  count, busy, done, state
    );

    modport slave (
        input  start, load_val, mode, pause, abort,
        output count, busy, done, state
    );
endinterface

// File: rtl/timer_seq_ctrl_dn_counter.sv
// WIDTH-bit down-counter register: load has priority over decrement,
// is_one flags the terminal value one cycle before zero.
module dn_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dec_en,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    // Counter register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            count <= {WIDTH{1'b0}};
        end else if (load) begin
            count <= load_data;
        end else if (dec_en) begin
            count <= count - WIDTH'(1);
        end else begin
            count <= count;
        end
    end

    assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/timer_seq_ctrl.sv
// Down-counter sequencer: one-shot/periodic intervals with pause and abort,
// busy level and a registered one-cycle terminal-count pulse.
module timer_seq_ctrl
    import timer_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 clr,
    timer_seq_ctrl_if.slave      bus
);

    state_t           state_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] reload_r;
    logic             mode_r;

    logic             ctl_load_s;
    logic [WIDTH-1:0] ctl_data_s;
    logic             ctl_dec_s;
    logic             is_one_s;
    logic             start_ok_s;

    assign start_ok_s = bus.start && (bus.load_val != {WIDTH{1'b0}});

    // Counter command decode; follows the same priority as the FSM below
    always_comb begin
        ctl_load_s = 1'b0;
        ctl_data_s = {WIDTH{1'b0}};
        ctl_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.abort) begin
                    ctl_load_s = 1'b1;
                end else if (!bus.pause && start_ok_s) begin
                    ctl_load_s = 1'b1;
                    ctl_data_s = bus.load_val;
                end else begin
                    ctl_load_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    ctl_load_s = 1'b1;
                end else if (bus.pause) begin
                    ctl_dec_s = 1'b0;
                end else if (is_one_s && (mode_r == MODE_PERIODIC)) begin
                    ctl_load_s = 1'b1;
                    ctl_data_s = reload_r;
                end else begin
                    ctl_dec_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.abort) begin
                    ctl_load_s = 1'b1;
                end else begin
                    ctl_load_s = 1'b0;
                end
            end
            default: begin
                ctl_load_s = 1'b1;
            end
        endcase
    end

    // Sequencer FSM with registered busy/done and latched interval settings
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            reload_r <= {WIDTH{1'b0}};
            mode_r   <= MODE_ONESHOT;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!bus.abort && !bus.pause && bus.start) begin
                        if (start_ok_s) begin
                            reload_r <= bus.load_val;
                            mode_r   <= bus.mode;
                            state_r  <= ST_RUN;
                            busy_r   <= 1'b1;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bus.pause) begin
                        state_r <= ST_HOLD;
                    end else if (is_one_s) begin
                        done_r <= 1'b1;
                        if (mode_r == MODE_ONESHOT) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (!bus.pause) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    dn_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk       (clk),
        .clr       (clr),
        .load      (ctl_load_s),
        .load_data (ctl_data_s),
        .dec_en    (ctl_dec_s),
        .count     (bus.count),
        .is_one    (is_one_s)
    );

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.state = state_r;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed, table-driven bench for timer_seq_ctrl (WIDTH=6) plus a few
// hand-written multi-cycle sequences.
module tb_timer_seq_ctrl;
    localparam int W = 6;

    typedef struct {
        logic         clr;
        logic         start;
        logic [W-1:0] load_val;
        logic         mode;
        logic         pause;
        logic         abort;
        int           e_count;
        int           e_busy;
        int           e_done;
        int           e_state;
    } vec_t;

    logic clk;
    logic clr;
    int   tests;
    int   failed;
    vec_t vecs[$];

    timer_seq_ctrl_if #(.WIDTH(W)) bus ();

    timer_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic c, input logic s, input int lv, input logic m,
                       input logic p, input logic a, input int ec, input int eb,
                       input int ed, input int es);
        vec_t v;
        v.clr = c; v.start = s; v.load_val = W'(lv); v.mode = m;
        v.pause = p; v.abort = a;
        v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_state = es;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic c, input logic s, input int lv, input logic m,
                         input logic p, input logic a);
        clr = c; bus.start = s; bus.load_val = W'(lv); bus.mode = m;
        bus.pause = p; bus.abort = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ec, input int eb,
                             input int ed, input int es);
        check({tag, ".count"}, int'(bus.count), ec);
        check({tag, ".busy"},  int'(bus.busy),  eb);
        check({tag, ".done"},  int'(bus.done),  ed);
        check({tag, ".state"}, int'(bus.state), es);
    endtask

    initial begin
        int edges;
        tests = 0;
        failed = 0;
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // reset with start asserted, then release
        add(0,1,9,0,0,0,  0,0,0,0);
        add(0,1,9,0,0,0,  0,0,0,0);
        add(1,0,0,0,0,0,  0,0,0,0);
        add(1,0,0,0,0,0,  0,0,0,0);
        // one-shot of 5
        add(1,1,5,0,0,0,  5,1,0,1);
        add(1,0,0,0,0,0,  4,1,0,1);
        add(1,0,0,0,0,0,  3,1,0,1);
        add(1,0,0,0,0,0,  2,1,0,1);
        add(1,0,0,0,0,0,  1,1,0,1);
        add(1,0,0,0,0,0,  0,0,1,0);
        add(1,0,0,0,0,0,  0,0,0,0);
        // periodic of 3, abort at count 2
        add(1,1,3,1,0,0,  3,1,0,1);
        add(1,0,0,0,0,0,  2,1,0,1);
        add(1,0,0,0,0,0,  1,1,0,1);
        add(1,0,0,0,0,0,  3,1,1,1);
        add(1,0,0,0,0,0,  2,1,0,1);
        add(1,0,0,0,0,0,  1,1,0,1);
        add(1,0,0,0,0,0,  3,1,1,1);
        add(1,0,0,0,0,0,  2,1,0,1);
        add(1,0,0,0,0,1,  0,0,0,0);
        add(1,0,0,0,0,0,  0,0,0,0);
        // pause at count 4 for 3 cycles
        add(1,1,6,0,0,0,  6,1,0,1);
        add(1,0,0,0,0,0,  5,1,0,1);
        add(1,0,0,0,0,0,  4,1,0,1);
        add(1,0,0,0,1,0,  4,1,0,2);
        add(1,0,0,0,1,0,  4,1,0,2);
        add(1,0,0,0,1,0,  4,1,0,2);
        add(1,0,0,0,0,0,  4,1,0,1);
        add(1,0,0,0,0,0,  3,1,0,1);
        add(1,0,0,0,0,0,  2,1,0,1);
        add(1,0,0,0,0,0,  1,1,0,1);
        add(1,0,0,0,0,0,  0,0,1,0);
        // zero length, then start while busy
        add(1,1,0,0,0,0,  0,0,1,0);
        add(1,0,0,0,0,0,  0,0,0,0);
        add(1,1,6,0,0,0,  6,1,0,1);
        add(1,0,0,0,0,0,  5,1,0,1);
        add(1,0,0,0,0,0,  4,1,0,1);
        add(1,1,9,1,0,0,  3,1,0,1);
        add(1,0,0,0,0,0,  2,1,0,1);
        add(1,0,0,0,0,0,  1,1,0,1);
        add(1,0,0,0,0,0,  0,0,1,0);
        // precedence: abort over start, clr mid-run, clr in HOLD
        add(1,1,5,0,0,1,  0,0,0,0);
        add(1,1,12,0,0,0, 12,1,0,1);
        add(1,0,0,0,0,0,  11,1,0,1);
        add(1,0,0,0,0,0,  10,1,0,1);
        add(0,0,0,0,0,0,  0,0,0,0);
        add(1,1,8,0,0,0,  8,1,0,1);
        add(1,0,0,0,1,0,  8,1,0,2);
        add(0,0,0,0,1,0,  0,0,0,0);
        add(1,0,0,0,0,0,  0,0,0,0);
        // abort at count 1 suppresses done
        add(1,1,2,0,0,0,  2,1,0,1);
        add(1,0,0,0,0,0,  1,1,0,1);
        add(1,0,0,0,0,1,  0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].start, int'(vecs[i].load_val), vecs[i].mode,
                  vecs[i].pause, vecs[i].abort);
            step();
            check_all($sformatf("v%0d", i), vecs[i].e_count, vecs[i].e_busy,
                      vecs[i].e_done, vecs[i].e_state);
        end

        // periodic with reload 1: done every cycle
        drive(1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        step();
        check_all("p1_start", 1, 1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_all($sformatf("p1_c%0d", k), 1, 1, 1, 1);
        end
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("p1_abort", 0, 0, 0, 0);

        // maximum interval: done exactly 63 edges after the accepting edge
        drive(1'b1, 1'b1, 63, 1'b0, 1'b0, 1'b0);
        step();
        check_all("max_start", 63, 1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 80) begin
            step();
            edges++;
        end
        check("max_latency", edges, 62 + 1);
        check_all("max_end", 0, 0, 1, 0);
        step();
        check_all("max_idle", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
Sequencer for the team's down-counter datapath. It loads a start value, decrements once per clock, and supports pause, abort, one-shot and periodic (auto-reload) modes. It reports busy and a one-cycle terminal-count pulse. It sits between a host/FSM requesting timed intervals and the counter register.

Parameters:
WIDTH, 6, counter/load width in bits (WIDTH >= 2)

Ports:
clk  input  1  single clock; all state changes on its rising edge
clr  input  1  reset, synchronous, active-low (clr=0 sampled at posedge resets the block)
start  input  1  request to begin a new interval; sampled only in IDLE
load_val  input  WIDTH  interval length in cycles; sampled when start is accepted
mode  input  1  0 = one-shot, 1 = periodic; latched with load_val
pause  input  1  level; freezes counting while high
abort  input  1  cancels any interval; returns to IDLE
count  output  WIDTH  current counter value (registered)
busy  output  1  high in RUN and HOLD
done  output  1  registered one-cycle terminal-count pulse
state  output  2  current FSM state, for debug/observation

Behaviour:
- Reset (clr=0 at posedge): state=IDLE, count=0, busy=0, done=0, reload reg=0, mode reg=0. Reset overrides all other inputs. Applies equally mid-interval.
- Priority at each edge: clr > abort > pause > terminal/decrement > start.
- done defaults to 0 every cycle. It is 1 only on the edges listed below.
- IDLE, start=1, load_val!=0: count<=load_val, reload<=load_val, mode_r<=mode, state<=RUN, busy<=1.
- IDLE, start=1, load_val==0: done<=1 for one cycle. State stays IDLE, busy=0, count=0.
- IDLE, start=0: hold all registers.
- RUN, pause=0, count>1: count<=count-1.
- RUN, pause=0, count==1, mode_r=0: count<=0, done<=1, busy<=0, state<=IDLE.
- RUN, pause=0, count==1, mode_r=1: count<=reload, done<=1, stays RUN. Period = reload cycles. With reload==1, done is high every cycle.
- RUN, pause=1: state<=HOLD, count frozen, busy stays 1.
- HOLD, pause=1: frozen.
- HOLD, pause=0: state<=RUN, no decrement on that edge. Decrementing resumes on the following edge.
- abort=1 in any state: state<=IDLE, count<=0, busy<=0, done<=0. No done pulse is emitted, even if count==1.
- start while busy: ignored. load_val and mode are ignored outside accepted start.
- Latency: start accepted at edge t. One-shot with N>0 gives done=1 and count=0 after edge t+N, provided there is no pause.
- Arithmetic: unsigned, modulo 2^WIDTH. Underflow is impossible because the terminal action occurs at count==1.
- State encoding: IDLE=2'b00, RUN=2'b01, HOLD=2'b10. 2'b11 is illegal and recovers to IDLE with count=0 on the next edge.

Decomposition:
- Shared package holds the state encodings (ST_IDLE, ST_RUN, ST_HOLD), the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1) and the default WIDTH.
- One sub-module is natural: dn_counter, a WIDTH-bit synchronous register with load, load_data and dec_en inputs and count and is_one outputs. The FSM drives it.

Test Plan:
1. clr=0 for 2 edges with start=1, load_val=9 -> count=0, busy=0, done=0, state=00 throughout. Release clr -> remains IDLE until start.
2. One-shot: start=1, load_val=5, mode=0 -> count 5,4,3,2,1,0 on successive edges. done=1 and busy=0 exactly on the edge count reaches 0. Then IDLE.
3. Periodic: load_val=3, mode=1 -> count 3,2,1,3,2,1,3. done pulses on each 1->3 edge, every 3 cycles. abort at count=2 -> count=0, busy=0, no done.
4. Pause: load_val=6 one-shot. pause=1 when count=4 for 3 cycles -> state=HOLD, count=4. pause=0 -> state=RUN with count=4, then 3 on the next edge. done arrives 1 cycle late relative to the pause length.
5. Zero length: start=1, load_val=0 -> done=1 for exactly one cycle, busy stays 0, count=0. Also start=1 while busy (count=4) -> ignored, count continues 3.
6. Precedence: abort=1 and start=1 in IDLE -> stays IDLE, count=0. clr=0 while count=10 (WIDTH=6) -> next edge count=0, busy=0. clr=0 with pause=1 in HOLD -> IDLE.
